// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and UART-side signals of the shared UART transmitter arbiter.
// The arbiter takes the slave view; producers and the UART together form the master view.
interface uart_tx_arbiter_if #(
    parameter int unsigned NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_REQ-1:0]   grant;
    logic                 uart_tx_start;
    logic [7:0]           uart_tx_data;
    logic                 uart_tx_busy;
    logic                 active;

    modport master (
        output req_valid,
        output req_data,
        output req_last,
        output uart_tx_busy,
        input  req_ready,
        input  grant,
        input  uart_tx_start,
        input  uart_tx_data,
        input  active
    );

    modport slave (
        input  req_valid,
        input  req_data,
        input  req_last,
        input  uart_tx_busy,
        output req_ready,
        output grant,
        output uart_tx_start,
        output uart_tx_data,
        output active
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte streams.
// A grant is locked for a whole packet, released on its last byte or after a stall timeout.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ       = 4,
    parameter int unsigned STALL_TIMEOUT = 1024
) (
    input logic               clk,
    input logic               rst,
    uart_tx_arbiter_if.slave  bus
);

    localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CntW = (STALL_TIMEOUT > 1) ? $clog2(STALL_TIMEOUT + 1) : 1;

    localparam logic [1:0] StIdle     = 2'd0;
    localparam logic [1:0] StSend     = 2'd1;
    localparam logic [1:0] StWaitBusy = 2'd2;
    localparam logic [1:0] StWaitDone = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IdxW-1:0]    rr_ptr_q, rr_ptr_d;
    logic               last_q, last_d;
    logic [CntW-1:0]    stall_cnt_q, stall_cnt_d;
    logic               start_q, start_d;
    logic [7:0]         data_q, data_d;

    logic [NUM_REQ-1:0] pick_oh;
    logic               pick_found;
    logic [IdxW-1:0]    cand;
    logic [IdxW-1:0]    g_idx;
    logic [IdxW-1:0]    g_next;
    logic               sel_valid;
    logic               sel_last;
    logic [7:0]         sel_data;

    // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        pick_oh    = '0;
        pick_found = 1'b0;
        cand       = '0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            cand = IdxW'((32'(rr_ptr_q) + off) % NUM_REQ);
            if (!pick_found && bus.req_valid[cand]) begin
                pick_found    = 1'b1;
                pick_oh       = '0;
                pick_oh[cand] = 1'b1;
            end
        end
    end

    always_comb begin
        g_idx     = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = 8'h00;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_q[i]) begin
                g_idx     = IdxW'(i);
                sel_valid = bus.req_valid[i];
                sel_last  = bus.req_last[i];
                sel_data  = bus.req_data[8*i +: 8];
            end
        end
        g_next = (g_idx == IdxW'(NUM_REQ - 1)) ? '0 : g_idx + IdxW'(1);
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        last_d      = last_q;
        stall_cnt_d = stall_cnt_q;
        start_d     = 1'b0;
        data_d      = data_q;

        case (state_q)
            StIdle: begin
                if (pick_found) begin
                    grant_d     = pick_oh;
                    stall_cnt_d = '0;
                    state_d     = StSend;
                end
            end
            StSend: begin
                // A busy UART freezes both acceptance and the stall timer.
                if (!bus.uart_tx_busy) begin
                    if (sel_valid) begin
                        data_d      = sel_data;
                        last_d      = sel_last;
                        start_d     = 1'b1;
                        stall_cnt_d = '0;
                        state_d     = StWaitBusy;
                    end else if (stall_cnt_q == CntW'(STALL_TIMEOUT - 1)) begin
                        grant_d     = '0;
                        rr_ptr_d    = g_next;
                        stall_cnt_d = '0;
                        state_d     = StIdle;
                    end else begin
                        stall_cnt_d = stall_cnt_q + CntW'(1);
                    end
                end
            end
            StWaitBusy: begin
                if (bus.uart_tx_busy) begin
                    state_d = StWaitDone;
                end
            end
            StWaitDone: begin
                if (!bus.uart_tx_busy) begin
                    if (last_q) begin
                        grant_d  = '0;
                        rr_ptr_d = g_next;
                        state_d  = StIdle;
                    end else begin
                        state_d = StSend;
                    end
                end
            end
            default: begin
                grant_d = '0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            last_q      <= 1'b0;
            stall_cnt_q <= '0;
            start_q     <= 1'b0;
            data_q      <= 8'h00;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            last_q      <= last_d;
            stall_cnt_q <= stall_cnt_d;
            start_q     <= start_d;
            data_q      <= data_d;
        end
    end

    assign bus.req_ready     = (state_q == StSend && !bus.uart_tx_busy) ? grant_q : '0;
    assign bus.grant         = grant_q;
    assign bus.uart_tx_start = start_q;
    assign bus.uart_tx_data  = data_q;
    assign bus.active        = (state_q != StIdle);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: queued producers, a UART busy model and a start-pulse log.
module tb_uart_tx_arbiter;

    localparam int unsigned NReq    = 4;
    localparam int unsigned StallTo = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NUM_REQ(NReq)) bus ();

    uart_tx_arbiter #(
        .NUM_REQ      (NReq),
        .STALL_TIMEOUT(StallTo)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic [NReq-1:0]   tb_valid = '0;
    logic [NReq-1:0]   tb_last  = '0;
    logic [8*NReq-1:0] tb_data  = '0;
    logic              model_busy = 1'b0;
    logic              ext_busy   = 1'b0;

    assign bus.req_valid    = tb_valid;
    assign bus.req_data     = tb_data;
    assign bus.req_last     = tb_last;
    assign bus.uart_tx_busy = model_busy | ext_busy;

    int errors = 0;
    int checks = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // UART model: busy rises the cycle after a start pulse and stays high 20 cycles.
    int busy_cnt = 0;
    always @(posedge clk) begin
        if (bus.uart_tx_start) begin
            model_busy <= 1'b1;
            busy_cnt   <= 19;
        end else if (busy_cnt > 0) begin
            busy_cnt <= busy_cnt - 1;
        end else begin
            model_busy <= 1'b0;
        end
    end

    // Start-pulse log plus per-pulse protocol checks.
    logic [7:0] log_data [64];
    logic [3:0] log_gnt  [64];
    int         log_n      = 0;
    logic       start_prev = 1'b0;
    always @(negedge clk) begin
        if (bus.uart_tx_start) begin
            check_eq("start_width", 32'(start_prev), 0);
            check_eq("start_while_busy", 32'(bus.uart_tx_busy), 0);
            if (log_n < 64) begin
                log_data[log_n] = bus.uart_tx_data;
                log_gnt[log_n]  = bus.grant;
                log_n++;
            end
        end
        start_prev = bus.uart_tx_start;
    end

    // Per-requester byte queues; head advances after each accepted byte.
    logic [8:0]      mem  [NReq][64];
    int              head [NReq] = '{default: 0};
    int              tail [NReq] = '{default: 0};
    logic [NReq-1:0] acc = '0;
    always @(negedge clk) begin
        for (int i = 0; i < NReq; i++) begin
            if (acc[i] && head[i] != tail[i]) head[i] = head[i] + 1;
            if (head[i] != tail[i]) begin
                tb_valid[i]       = 1'b1;
                tb_data[8*i +: 8] = mem[i][head[i]][7:0];
                tb_last[i]        = mem[i][head[i]][8];
            end else begin
                tb_valid[i] = 1'b0;
                tb_last[i]  = 1'b0;
            end
        end
        acc = rst ? '0 : (tb_valid & bus.req_ready);
    end

    task automatic push(input int i, input logic [7:0] d, input logic l);
        mem[i][tail[i]] = {l, d};
        tail[i] = tail[i] + 1;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic wait_log(input int n, input int budget);
        int b = 0;
        while (log_n < n && b < budget) begin
            tick(1);
            b++;
        end
        check_eq("wait_log", log_n, n);
    endtask

    task automatic wait_idle(input int budget);
        int b = 0;
        while (bus.active && b < budget) begin
            tick(1);
            b++;
        end
        check_eq("wait_idle", 32'(bus.active), 0);
    endtask

    task automatic wait_ready(input logic [3:0] exp, input int budget);
        int b = 0;
        while (bus.req_ready != exp && b < budget) begin
            tick(1);
            b++;
        end
        check_eq("wait_ready", bus.req_ready, exp);
    endtask

    task automatic check_log(input int idx, input logic [7:0] d, input logic [3:0] g);
        check_eq("log_data", log_data[idx], d);
        check_eq("log_grant", log_gnt[idx], g);
    endtask

    initial begin
        int base;
        int cnt;
        int b;

        // Reset state
        do_reset();
        check_eq("rst_grant", bus.grant, 0);
        check_eq("rst_start", 32'(bus.uart_tx_start), 0);
        check_eq("rst_data", bus.uart_tx_data, 0);
        check_eq("rst_active", 32'(bus.active), 0);
        check_eq("rst_ready", bus.req_ready, 0);

        // Single requester, 3-byte packet
        base = log_n;
        push(0, 8'h41, 1'b0);
        push(0, 8'h42, 1'b0);
        push(0, 8'h43, 1'b1);
        tick(1);
        check_eq("t1_grant_latency", bus.grant, 4'b0001);
        check_eq("t1_active", 32'(bus.active), 1);
        wait_log(base + 3, 500);
        wait_idle(100);
        check_log(base + 0, 8'h41, 4'b0001);
        check_log(base + 1, 8'h42, 4'b0001);
        check_log(base + 2, 8'h43, 4'b0001);
        check_eq("t1_grant_released", bus.grant, 0);

        // rr_ptr is now 1: requester 1 beats requester 0
        base = log_n;
        push(0, 8'h50, 1'b1);
        push(1, 8'h51, 1'b1);
        tick(1);
        check_eq("t1_rr_after_pkt", bus.grant, 4'b0010);
        wait_log(base + 2, 500);
        wait_idle(100);
        check_log(base + 0, 8'h51, 4'b0010);
        check_log(base + 1, 8'h50, 4'b0001);

        // Requesters 1 and 2 together, rr_ptr = 0
        do_reset();
        base = log_n;
        push(1, 8'h11, 1'b0);
        push(1, 8'h12, 1'b1);
        push(2, 8'h21, 1'b0);
        push(2, 8'h22, 1'b1);
        tick(1);
        check_eq("t2_first_grant", bus.grant, 4'b0010);
        check_eq("t2_ready_loser", bus.req_ready & 4'b0100, 0);
        wait_log(base + 4, 500);
        wait_idle(100);
        check_log(base + 0, 8'h11, 4'b0010);
        check_log(base + 1, 8'h12, 4'b0010);
        check_log(base + 2, 8'h21, 4'b0100);
        check_log(base + 3, 8'h22, 4'b0100);

        // All four continuously valid with 1-byte packets
        do_reset();
        base = log_n;
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < NReq; i++) push(i, 8'(8'h30 + 8 * p + i), 1'b1);
        end
        wait_log(base + 8, 1000);
        wait_idle(100);
        for (int k = 0; k < 8; k++) begin
            check_log(base + k, 8'(8'h30 + 8 * (k / 4) + (k % 4)), 4'(1 << (k % 4)));
        end

        // Stall timeout on requester 3, then requester 0 is served
        do_reset();
        base = log_n;
        push(3, 8'h77, 1'b0);
        tick(1);
        check_eq("t4_grant", bus.grant, 4'b1000);
        wait_log(base + 1, 100);
        push(0, 8'h05, 1'b1);
        wait_ready(4'b1000, 100);
        cnt = 0;
        b   = 0;
        while (bus.grant == 4'b1000 && b < 100) begin
            if (bus.req_ready[3]) cnt++;
            tick(1);
            b++;
        end
        check_eq("t4_stall_cycles", cnt, StallTo);
        check_eq("t4_released_grant", bus.grant, 0);
        check_eq("t4_released_active", 32'(bus.active), 0);
        tick(1);
        check_eq("t4_next_grant", bus.grant, 4'b0001);
        wait_log(base + 2, 200);
        wait_idle(100);
        check_log(base + 0, 8'h77, 4'b1000);
        check_log(base + 1, 8'h05, 4'b0001);

        // Reset while in WAIT_DONE mid-packet
        do_reset();
        base = log_n;
        push(2, 8'h61, 1'b0);
        push(2, 8'h62, 1'b1);
        wait_log(base + 1, 100);
        tick(1);
        check_eq("t5_busy_before_rst", 32'(bus.uart_tx_busy), 1);
        check_eq("t5_active_before_rst", 32'(bus.active), 1);
        rst = 1'b1;
        push(0, 8'h0a, 1'b1);
        tick(1);
        check_eq("t5_rst_grant", bus.grant, 0);
        check_eq("t5_rst_start", 32'(bus.uart_tx_start), 0);
        check_eq("t5_rst_data", bus.uart_tx_data, 0);
        check_eq("t5_rst_active", 32'(bus.active), 0);
        check_eq("t5_rst_ready", bus.req_ready, 0);
        tick(1);
        rst  = 1'b0;
        base = log_n;
        tick(1);
        check_eq("t5_restart_grant", bus.grant, 4'b0001);
        wait_log(base + 2, 300);
        wait_idle(100);
        check_log(base + 0, 8'h0a, 4'b0001);
        check_log(base + 1, 8'h62, 4'b0100);

        // External busy in SEND: no accept, no stall progress
        do_reset();
        base = log_n;
        push(0, 8'h99, 1'b0);
        wait_log(base + 1, 100);
        wait_ready(4'b0001, 100);
        ext_busy = 1'b1;
        tick(30);
        check_eq("t6_grant_held", bus.grant, 4'b0001);
        check_eq("t6_ready_busy", bus.req_ready, 0);
        push(0, 8'h9a, 1'b1);
        tick(5);
        check_eq("t6_ready_valid_busy", bus.req_ready, 0);
        check_eq("t6_no_start", log_n, base + 1);
        ext_busy = 1'b0;
        #1;
        check_eq("t6_ready_free", bus.req_ready, 4'b0001);
        tick(1);
        check_eq("t6_start", 32'(bus.uart_tx_start), 1);
        check_eq("t6_data", bus.uart_tx_data, 8'h9a);
        wait_idle(100);
        check_eq("t6_log_count", log_n, base + 2);
        check_log(base + 1, 8'h9a, 4'b0001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
